// File: rtl/mmss_timer.sv
// MM:SS BCD timer with load/start/pause/clear control, up/down counting and optional wrap.
// Latency: one cycle from tick or control to registered outputs. Backpressure: none; every input is acted on in its own cycle.
module mmss_timer #(
    parameter int SEC_TENS_MOD = 6,
    parameter int MIN_TENS_MOD = 6,
    parameter int WRAP         = 0
) (
    input  logic        clk_out,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        mode,
    output logic [15:0] digits,
    output logic [1:0]  state,
    output logic        done,
    output logic        term_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [3:0]  S_TENS_MAX   = 4'(SEC_TENS_MOD - 1);
    localparam logic [3:0]  M_TENS_MAX   = 4'(MIN_TENS_MOD - 1);
    localparam logic [15:0] MAX_COUNT    = {M_TENS_MAX, 4'd9, S_TENS_MAX, 4'd9};
    localparam bit          STOP_AT_TERM = (WRAP == 0);

    state_t      st;
    logic [15:0] cnt_next;
    logic        term_hit;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [15:0] clamp_value(input logic [15:0] v);
        return {clamp_digit(v[15:12], M_TENS_MAX), clamp_digit(v[11:8], 4'd9),
                clamp_digit(v[7:4], S_TENS_MAX), clamp_digit(v[3:0], 4'd9)};
    endfunction

    // A digit steps only when every digit below it rolls over.
    function automatic logic [15:0] count_down(input logic [15:0] d);
        logic [15:0] n;
        logic        b0;
        logic        b1;
        logic        b2;
        n  = d;
        b0 = (d[3:0] == 4'd0);
        b1 = b0 && (d[7:4] == 4'd0);
        b2 = b1 && (d[11:8] == 4'd0);
        n[3:0] = b0 ? 4'd9 : d[3:0] - 4'd1;
        if (b0) begin
            n[7:4] = (d[7:4] == 4'd0) ? S_TENS_MAX : d[7:4] - 4'd1;
        end
        if (b1) begin
            n[11:8] = (d[11:8] == 4'd0) ? 4'd9 : d[11:8] - 4'd1;
        end
        if (b2) begin
            n[15:12] = (d[15:12] == 4'd0) ? M_TENS_MAX : d[15:12] - 4'd1;
        end
        return n;
    endfunction

    function automatic logic [15:0] count_up(input logic [15:0] d);
        logic [15:0] n;
        logic        c0;
        logic        c1;
        logic        c2;
        n  = d;
        c0 = (d[3:0] == 4'd9);
        c1 = c0 && (d[7:4] == S_TENS_MAX);
        c2 = c1 && (d[11:8] == 4'd9);
        n[3:0] = c0 ? 4'd0 : d[3:0] + 4'd1;
        if (c0) begin
            n[7:4] = (d[7:4] == S_TENS_MAX) ? 4'd0 : d[7:4] + 4'd1;
        end
        if (c1) begin
            n[11:8] = (d[11:8] == 4'd9) ? 4'd0 : d[11:8] + 4'd1;
        end
        if (c2) begin
            n[15:12] = (d[15:12] == M_TENS_MAX) ? 4'd0 : d[15:12] + 4'd1;
        end
        return n;
    endfunction

    assign cnt_next = mode ? count_up(digits) : count_down(digits);
    assign term_hit = (cnt_next == (mode ? MAX_COUNT : 16'h0000));
    assign state    = st;

    // Priority chain: clear, accepted load, pause, start, tick.
    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            digits     <= 16'h0000;
            st         <= ST_IDLE;
            done       <= 1'b0;
            term_pulse <= 1'b0;
        end else begin
            term_pulse <= 1'b0;
            if (clear) begin
                digits <= 16'h0000;
                st     <= ST_IDLE;
                done   <= 1'b0;
            end else if (load && (st == ST_IDLE || st == ST_PAUSE)) begin
                digits <= clamp_value(load_value);
            end else if (pause) begin
                if (st == ST_RUN) begin
                    st <= ST_PAUSE;
                end
            end else if (start && st == ST_IDLE) begin
                // Starting a down-count already at zero has nothing to count.
                if (!mode && digits == 16'h0000 && STOP_AT_TERM) begin
                    st         <= ST_DONE;
                    done       <= 1'b1;
                    term_pulse <= 1'b1;
                end else begin
                    st <= ST_RUN;
                end
            end else if (start && st == ST_PAUSE) begin
                st <= ST_RUN;
            end else if (tick && st == ST_RUN) begin
                digits <= cnt_next;
                if (term_hit) begin
                    term_pulse <= 1'b1;
                    if (STOP_AT_TERM) begin
                        st   <= ST_DONE;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// Bench for mmss_timer: stop and wrap instances driven in parallel, checked against a seconds-count model.
module tb_mmss_timer;

    localparam int SM = 6;
    localparam int MM = 6;
    localparam int N  = MM * 10 * SM * 10;

    logic        clk_out = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick, start, pause, clear, load, mode;
    logic [15:0] load_value;
    logic [15:0] dig0, dig1;
    logic [1:0]  st0, st1;
    logic        done0, done1, tp0, tp1;

    int n_chk  = 0;
    int n_fail = 0;
    int m_cnt[2];
    int m_st[2];
    bit m_tp[2];

    always #5 clk_out = ~clk_out;

    mmss_timer #(.SEC_TENS_MOD(SM), .MIN_TENS_MOD(MM), .WRAP(0)) u_dut0 (
        .clk_out(clk_out), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .load(load), .load_value(load_value), .mode(mode),
        .digits(dig0), .state(st0), .done(done0), .term_pulse(tp0)
    );

    mmss_timer #(.SEC_TENS_MOD(SM), .MIN_TENS_MOD(MM), .WRAP(1)) u_dut1 (
        .clk_out(clk_out), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .load(load), .load_value(load_value), .mode(mode),
        .digits(dig1), .state(st1), .done(done1), .term_pulse(tp1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int c);
        int so, stn, mo, mt;
        so  = c % 10;  c = c / 10;
        stn = c % SM;  c = c / SM;
        mo  = c % 10;
        mt  = c / 10;
        return {4'(mt), 4'(mo), 4'(stn), 4'(so)};
    endfunction

    function automatic int clamp_cnt(input logic [15:0] v);
        int so, stn, mo, mt;
        mt  = int'(v[15:12]); if (mt > MM - 1) mt = MM - 1;
        mo  = int'(v[11:8]);  if (mo > 9) mo = 9;
        stn = int'(v[7:4]);   if (stn > SM - 1) stn = SM - 1;
        so  = int'(v[3:0]);   if (so > 9) so = 9;
        return ((mt * 10 + mo) * SM + stn) * 10 + so;
    endfunction

    // States use the output encoding: 0 idle, 1 run, 2 pause, 3 done.
    task automatic model_step(input int w);
        m_tp[w] = 1'b0;
        if (clear) begin
            m_cnt[w] = 0;
            m_st[w]  = 0;
        end else if (load && (m_st[w] == 0 || m_st[w] == 2)) begin
            m_cnt[w] = clamp_cnt(load_value);
        end else if (pause) begin
            if (m_st[w] == 1) m_st[w] = 2;
        end else if (start && m_st[w] == 0) begin
            if (!mode && m_cnt[w] == 0 && w == 0) begin
                m_st[w] = 3;
                m_tp[w] = 1'b1;
            end else begin
                m_st[w] = 1;
            end
        end else if (start && m_st[w] == 2) begin
            m_st[w] = 1;
        end else if (tick && m_st[w] == 1) begin
            m_cnt[w] = mode ? (m_cnt[w] + 1) % N : (m_cnt[w] + N - 1) % N;
            if (m_cnt[w] == (mode ? N - 1 : 0)) begin
                m_tp[w] = 1'b1;
                if (w == 0) m_st[w] = 3;
            end
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_cnt[w] = 0;
            m_st[w]  = 0;
            m_tp[w]  = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("stop_digits", dig0, to_bcd(m_cnt[0]));
        check("stop_state",  16'(st0), 16'(m_st[0]));
        check("stop_done",   16'(done0), 16'(m_st[0] == 3));
        check("stop_term",   16'(tp0), 16'(m_tp[0]));
        check("wrap_digits", dig1, to_bcd(m_cnt[1]));
        check("wrap_state",  16'(st1), 16'(m_st[1]));
        check("wrap_done",   16'(done1), 16'(m_st[1] == 3));
        check("wrap_term",   16'(tp1), 16'(m_tp[1]));
    endtask

    task automatic drive(input bit c, input bit l, input bit p, input bit s, input bit t,
                         input logic [15:0] lv);
        clear = c; load = l; pause = p; start = s; tick = t; load_value = lv;
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk_out);
        #1;
        compare_all();
    endtask

    initial begin
        mode = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0000);
        model_reset();
        #2;
        compare_all();
        @(negedge clk_out);
        reset_n = 1'b1;
        step();

        // Countdown across a minute boundary
        drive(0, 1, 0, 0, 0, 16'h0100); step();
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        check("r37_run", 16'(st0), 16'd1);
        drive(0, 0, 0, 0, 1, 16'h0000); step(); check("r37_t1", dig0, 16'h0059);
        step(); check("r37_t2", dig0, 16'h0058);
        step(); check("r37_t3", dig0, 16'h0057);
        check("r37_noterm", 16'(tp0), 16'd0);

        // Down to terminal count, then stick in DONE
        drive(1, 0, 0, 0, 0, 16'h0000); step();
        drive(0, 1, 0, 0, 0, 16'h0002); step();
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        drive(0, 0, 0, 0, 1, 16'h0000); step(); check("r38_t1", dig0, 16'h0001);
        step();
        check("r38_zero", dig0, 16'h0000);
        check("r38_term", 16'(tp0), 16'd1);
        check("r38_done", 16'(st0), 16'd3);
        check("r38_wrap_run", 16'(st1), 16'd1);
        drive(0, 0, 0, 0, 0, 16'h0000); step(); check("r38_pulse1", 16'(tp0), 16'd0);
        drive(0, 0, 0, 0, 1, 16'h0000); step(); check("r38_wrapmax", dig1, 16'h5959);
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        check("r38_hold", dig0, 16'h0000);
        check("r38_hold_st", 16'(st0), 16'd3);

        // Start at zero counting down
        drive(1, 0, 0, 0, 0, 16'h0000); step();
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        check("r23_done", 16'(st0), 16'd3);
        check("r23_term", 16'(tp0), 16'd1);

        // Up-count with wrap
        mode = 1'b1;
        drive(1, 0, 0, 0, 0, 16'h0000); step();
        drive(0, 1, 0, 0, 0, 16'h5958); step();
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        drive(0, 0, 0, 0, 1, 16'h0000); step();
        check("r39_max", dig1, 16'h5959);
        check("r39_term", 16'(tp1), 16'd1);
        step();
        check("r39_wrap", dig1, 16'h0000);
        check("r39_run", 16'(st1), 16'd1);

        // Clamp on load, load ignored while running
        mode = 1'b0;
        drive(1, 0, 0, 0, 0, 16'h0000); step();
        drive(0, 1, 0, 0, 0, 16'hF9A7); step(); check("r40_clamp", dig0, 16'h5957);
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        drive(0, 1, 0, 0, 0, 16'h1234); step(); check("r40_ignored", dig0, 16'h5957);

        // Pause beats a coincident tick
        drive(0, 0, 1, 0, 1, 16'h0000); step();
        check("r41_hold", dig0, 16'h5957);
        check("r41_pause", 16'(st0), 16'd2);
        drive(0, 0, 0, 1, 0, 16'h0000); step(); check("r41_resume", 16'(st0), 16'd1);
        drive(0, 0, 0, 0, 1, 16'h0000); step(); check("r41_count", dig0, 16'h5956);

        // Asynchronous reset mid-run, then clear beating load
        drive(1, 0, 0, 0, 0, 16'h0000); step();
        drive(0, 1, 0, 0, 0, 16'h0330); step();
        drive(0, 0, 0, 1, 0, 16'h0000); step();
        drive(0, 0, 0, 0, 0, 16'h0000);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("r42_rst_dig", dig0, 16'h0000);
        check("r42_rst_st", 16'(st0), 16'd0);
        compare_all();
        #4;
        reset_n = 1'b1;
        step();
        drive(0, 1, 0, 0, 0, 16'h1111); step();
        drive(1, 1, 0, 0, 0, 16'h2222); step();
        check("r42_clr_dig", dig0, 16'h0000);
        check("r42_clr_st", 16'(st0), 16'd0);

        // Randomized control traffic
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] lv;
            case ($urandom_range(0, 2))
                0:       lv = 16'($urandom);
                1:       lv = {8'h00, 8'($urandom)};
                default: lv = {8'h59, 8'($urandom)};
            endcase
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 0, lv);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
